// File: rtl/ssub_serial.sv
// Bit-serial signed subtractor: diff = a - b, one bit per clock, LSB first.
// A single full-adder cell computes a + ~b + 1 with a registered carry.
module ssub_serial #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] diff,
    output logic                 ovf
);

    localparam int CW = $clog2(DATAWIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

    logic [1:0]           state;
    logic [DATAWIDTH-1:0] sa;
    logic [DATAWIDTH-1:0] sb;
    logic [DATAWIDTH-1:0] res;
    logic [CW-1:0]        cnt;
    logic                 carry;
    logic                 a_msb;
    logic                 b_msb;

    logic nb;
    logic sum_bit;
    logic carry_nx;

    // Full-adder cell on the current LSBs; the subtrahend bit is inverted.
    always_comb begin
        nb       = ~sb[0];
        sum_bit  = sa[0] ^ nb ^ carry;
        carry_nx = (sa[0] & nb) | (sa[0] & carry) | (nb & carry);
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // NOTE: every register here is assigned with <= so all updates in one
    // edge see the pre-edge values; blocking = would chain them within a cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        a_msb <= a[DATAWIDTH-1];
                        b_msb <= b[DATAWIDTH-1];
                        carry <= 1'b1;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= carry_nx;
                    res   <= {sum_bit, res[DATAWIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // The final bit is the sign of the result; publish it directly.
                        state <= DONE;
                        diff  <= {sum_bit, res[DATAWIDTH-1:1]};
                        ovf   <= (a_msb != b_msb) && (sum_bit != a_msb);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssub_serial.sv
// Directed bench for ssub_serial: 8-bit vector table, back-to-back, ignored
// start, asynchronous reset abort, and an exhaustive 2-bit sweep.
module tb_ssub_serial;

    logic clk = 1'b0;
    logic rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, ovf8;
    logic [7:0] diff8;

    logic       start2;
    logic [1:0] a2, b2;
    logic       busy2, done2, ovf2;
    logic [1:0] diff2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ssub_serial #(.DATAWIDTH(8)) dut8 (
        .Clk(clk), .Rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .ovf(ovf8)
    );

    ssub_serial #(.DATAWIDTH(2)) dut2 (
        .Clk(clk), .Rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .ovf(ovf2)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       ovf;
    } vec8_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done is seen; -1 if it never arrives.
    task automatic wait_done8(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            edges++;
            if (done8) return;
            if (busy8) busy_cnt++;
        end
        edges = -1;
    endtask

    task automatic wait_done2(output int edges);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (done2) return;
        end
        edges = -1;
    endtask

    task automatic op8(input logic [7:0] a_v, input logic [7:0] b_v,
                       input logic [7:0] exp_d, input logic exp_o, input string tag);
        int e, bc;
        a8 = a_v; b8 = b_v; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check({tag, " busy_after_start"}, busy8, 1);
        wait_done8(e, bc);
        check({tag, " latency"}, e, 8);
        check({tag, " busy_cycles"}, bc + 1, 8);
        check({tag, " diff"}, diff8, exp_d);
        check({tag, " ovf"}, ovf8, exp_o);
        tick();
        check({tag, " done_one_cycle"}, {busy8, done8}, 2'b00);
    endtask

    task automatic count_dones8(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done8) n++;
        end
    endtask

    vec8_t tbl [9];

    initial begin
        int e, bc, nd;

        tbl[0] = '{8'd5,    8'd3,    8'd2,    1'b0};
        tbl[1] = '{8'h80,   8'd1,    8'h7F,   1'b1};
        tbl[2] = '{8'd100,  8'h9C,   8'hC8,   1'b1};
        tbl[3] = '{8'hFB,   8'hFB,   8'h00,   1'b0};
        tbl[4] = '{8'h7F,   8'hFF,   8'h80,   1'b1};
        tbl[5] = '{8'hFF,   8'h7F,   8'h80,   1'b0};
        tbl[6] = '{8'h00,   8'h80,   8'h80,   1'b1};
        tbl[7] = '{8'd60,   8'd70,   8'hF6,   1'b0};
        tbl[8] = '{8'd10,   8'd4,    8'd6,    1'b0};

        rst = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        tick(); tick();
        check("reset8 outputs", {busy8, done8, diff8, ovf8}, '0);
        check("reset2 outputs", {busy2, done2, diff2, ovf2}, '0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++)
            op8(tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].ovf, $sformatf("vec%0d", i));

        // Back-to-back with start held high; operand changes mid-shift ignored.
        a8 = 8'd10; b8 = 8'd4; start8 = 1'b1;
        tick();
        a8 = 8'd55; b8 = 8'd33;
        wait_done8(e, bc);
        check("b2b first latency", e, 8);
        check("b2b first diff", diff8, 8'd6);
        a8 = 8'd7; b8 = 8'd9;
        tick();
        check("b2b no gap", {busy8, done8}, 2'b10);
        a8 = 8'hAA; b8 = 8'h11;
        wait_done8(e, bc);
        check("b2b second latency", e, 8);
        check("b2b second diff", diff8, 8'hFE);
        check("b2b second ovf", ovf8, 1'b0);
        start8 = 1'b0;
        tick();
        check("b2b end idle", {busy8, done8}, 2'b00);

        // Start pulsed while busy with different operands.
        a8 = 8'd20; b8 = 8'd5; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'd1; b8 = 8'd100; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(e, bc);
        check("ignore latency", e, 5);
        check("ignore diff", diff8, 8'h0F);
        check("ignore ovf", ovf8, 1'b0);
        count_dones8(20, nd);
        check("ignore single done", nd, 0);

        // Asynchronous reset in the middle of a shift.
        op8(8'h7F, 8'hFF, 8'h80, 1'b1, "pre_reset");
        a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick(); tick();
        check("abort busy before reset", busy8, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("abort outputs cleared", {busy8, done8, diff8, ovf8}, '0);
        tick();
        rst = 1'b1;
        count_dones8(20, nd);
        check("abort no done", nd, 0);
        op8(8'd50, 8'd20, 8'd30, 1'b0, "post_reset");

        // Exhaustive 2-bit sweep against a signed reference.
        for (int ai = -2; ai <= 1; ai++) begin
            for (int bi = -2; bi <= 1; bi++) begin
                int d;
                logic [1:0] ed;
                d  = ai - bi;
                ed = 2'(d);
                a2 = 2'(ai); b2 = 2'(bi); start2 = 1'b1;
                tick();
                start2 = 1'b0;
                wait_done2(e);
                check($sformatf("w2 %0d-%0d latency", ai, bi), e, 2);
                check($sformatf("w2 %0d-%0d diff", ai, bi), diff2, ed);
                check($sformatf("w2 %0d-%0d ovf", ai, bi), ovf2, (d > 1 || d < -2));
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ssub_serial.md
Name: ssub_serial

Overview:
- Bit-serial signed subtractor: diff = a - b, two's complement, one bit per clock, LSB first.
- Sequential counterpart to the combinational signed adder in the component library. Computes a + ~b + 1 through a single full-adder cell plus a borrow/carry flip-flop.
- Used by the datapath generator where area matters more than latency.
- Start/done handshake; result and overflow flag stay registered until the next operation.

Parameters:
- DATAWIDTH, 8, operand and result width in bits (signed). Legal range 2..64.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous active-low reset (0 = reset)
- start  input  1  request; sampled on Clk rising edge; accepted only in IDLE or DONE
- a  input  DATAWIDTH  signed minuend; sampled when start is accepted
- b  input  DATAWIDTH  signed subtrahend; sampled when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: diff/ovf valid
- diff  output  DATAWIDTH  signed result a - b, wrapped modulo 2^DATAWIDTH
- ovf  output  1  signed overflow of the subtraction

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, busy=0, done=0, diff=0, ovf=0. Operand shift registers, counter and carry are all cleared.
- Reset mid-operation aborts the operation; no done is produced after release.
- State machine: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - latch a into shift register SA and b into SB;
  - carry=1 (the +1 of two's-complement negation);
  - cnt=0, state=SHIFT, busy=1.
- SHIFT, each edge:
  - bit = SA[0] ^ ~SB[0] ^ carry;
  - carry = majority(SA[0], ~SB[0], carry);
  - shift bit into result register from the MSB side;
  - SA and SB shift right by one;
  - cnt increments.
- SHIFT exit: at the edge where cnt reaches DATAWIDTH-1 (edge E_DATAWIDTH):
  - state=DONE, busy=0;
  - diff loads the completed result register;
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the latched operand sign bits.
- Latency: start sampled at E0 -> done high for exactly the cycle following E_DATAWIDTH (DATAWIDTH edges after E0).
- DONE:
  - done=1 for one cycle; next edge returns to IDLE with done=0.
  - If start=1 at that edge, a new operation is accepted instead (back-to-back, no idle gap).
- diff/ovf hold their values through IDLE and the next operation. They change only at the completing edge of the next operation or on reset.
- start while busy=1 is ignored; operands changing during SHIFT have no effect.
- Arithmetic: result wraps modulo 2^DATAWIDTH; no saturation.
- The final carry-out is not an output; ovf is the only exception indicator.
- Counter width: clog2(DATAWIDTH)+1 bits; no wrap before terminal count.

Test Plan:
- DATAWIDTH=8, a=5, b=3, start 1 cycle -> busy high 8 cycles; done pulses 8 cycles after start edge; diff=2, ovf=0.
- a=-128, b=1 -> diff=127 (0x7F), ovf=1. Then a=100, b=-100 -> diff=-56 (0xC8), ovf=1. Then a=-5, b=-5 -> diff=0, ovf=0.
- start held high continuously with a=10, b=4, then a=7, b=9 presented on the DONE cycle:
  - first done gives diff=6;
  - second operation starts on the DONE edge with no gap;
  - next done gives diff=-2 (0xFE);
  - operand changes during SHIFT are ignored.
- Pulse start again at cycle 3 of an operation with different operands -> ignored; result matches the first operands; exactly one done.
- Assert Rst=0 asynchronously at cycle 4 of SHIFT -> busy, done, diff and ovf go to 0 immediately. No done after release; next start computes correctly.
- DATAWIDTH=2 sweep of all 16 operand pairs -> diff = (a-b) mod 4, with ovf matching a reference model; latency 2 cycles each.
